hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's hazard unit.
- Provides forwarding, load-use stall and branch flush for the 5-stage core.
- Adds a register scoreboard and an in-order completion queue so a variable-latency multi-cycle execute unit (mul/div) can run alongside the pipe.
- Sits beside the ID/EX/MEM/WB registers; its stall/flush outputs drive the IF/ID and ID/EX pipeline registers.

Parameters:
- NREG, 32, number of architectural registers; x0 is never tracked.
- RW, 5, register index width; NREG must not exceed 2^RW.
- MC_DEPTH, 2, maximum outstanding multi-cycle ops (completion-queue depth, ≥1).
- CW, 2, occupancy counter width; must satisfy 2^CW > MC_DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- rs1_d, rs2_d, rd_d  in  RW  Decode-stage source and destination indices
- regwrite_d  in  1  Decode instruction writes rd_d
- mc_issue_d  in  1  Decode instruction is a multi-cycle op
- rs1_e, rs2_e, rd_e  in  RW  Execute-stage indices
- regwrite_e  in  1  Execute instruction writes rd_e
- resultsrc_e  in  2  Execute result source; 2'b01 = load
- mc_issue_e  in  1  Execute instruction is being dispatched to the multi-cycle unit this cycle
- pcsrc_e  in  1  taken branch or jump in Execute
- rd_m  in  RW  Memory-stage destination
- regwrite_m  in  1  Memory-stage write enable
- rd_w  in  RW  Writeback-stage destination
- regwrite_w  in  1  Writeback-stage write enable
- mc_done  in  1  multi-cycle unit completes its oldest op this cycle
- forward_ae, forward_be  out  2  00 = register file, 10 = ALU result in Memory, 01 = ResultW
- stall_f, stall_d  out  1  hold PC and the IF/ID register
- flush_d, flush_e  out  1  clear the IF/ID and ID/EX registers
- mc_rd  out  RW  destination of the op completing now (queue head); valid when mc_done is 1
- mc_count  out  CW  outstanding multi-cycle ops (registered)
- busy  out  NREG  per-register pending-write bits (registered)
- mc_err  out  1  sticky protocol-error flag (registered)

Behaviour:
- Reset (rst = 0, async): busy = 0, mc_count = 0, queue head/tail = 0, mc_err = 0. A reset asserted mid-operation discards all outstanding entries; the multi-cycle unit is reset on the same line.
- Forwarding (combinational), per operand, e.g. rs1_e:
  - 10 if regwrite_m and rd_m == rs1_e and rs1_e != 0;
  - else 01 if regwrite_w and rd_w == rs1_e and rs1_e != 0;
  - else 00.
  - Memory stage wins over Writeback.
- Stall causes (combinational). Each applies only when the referenced index is nonzero.
  - lw: resultsrc_e == 01, and rd_e equals rs1_d or rs2_d.
  - raw: busy[rs1_d] or busy[rs2_d]; or mc_issue_e and regwrite_e and rd_e equals rs1_d or rs2_d.
  - waw: regwrite_d and (busy[rd_d], or mc_issue_e and rd_e == rd_d).
  - full: mc_issue_d and (mc_count + mc_issue_e) ≥ MC_DEPTH. This check deliberately ignores mc_done.
  - hz = lw | raw | waw | full.
- Output priority:
  - pcsrc_e = 1: flush_d = 1, flush_e = 1, stall_f = stall_d = 0. Redirect wins because the stalled Decode instruction is being squashed.
  - Otherwise: stall_f = stall_d = hz, flush_e = hz, flush_d = 0.
- Issue, at the clock edge when mc_issue_e = 1:
  - push rd_e at the queue tail (tail wraps mod MC_DEPTH) and increment mc_count;
  - if regwrite_e and rd_e != 0, set busy[rd_e].
  - Issue with mc_count == MC_DEPTH and no simultaneous mc_done: push dropped, mc_err set.
- Completion, at the clock edge when mc_done = 1:
  - mc_rd = queue head (combinational);
  - pop the head (head wraps mod MC_DEPTH), decrement mc_count, clear busy[mc_rd].
  - mc_done with mc_count == 0: ignored, mc_rd = 0, mc_err set.
- Issue and completion in the same cycle:
  - mc_count is unchanged;
  - if the same register is set and cleared, set wins;
  - when mc_count == MC_DEPTH, push and pop both succeed.
- Completions are strictly in order. The WAW stall guarantees each register appears at most once in the queue.
- Results return via the W stage, so forwarding of multi-cycle results uses the 01 path.
- mc_err clears only on reset.

Test Plan:
- Forwarding: regwrite_m = 1, rd_m = 5, regwrite_w = 1, rd_w = 5, rs1_e = 5, rs2_e = 0 -> forward_ae = 10, forward_be = 00.
- Load-use: resultsrc_e = 01, rd_e = 7, rs2_d = 7 -> stall_f = stall_d = flush_e = 1 for one cycle. Same stimulus with rd_e = 0 -> no stall.
- Scoreboard: mc_issue_e with rd_e = 3, regwrite_e = 1 -> busy[3] = 1 next cycle. rs1_d = 3 stalls until mc_done, after which mc_rd = 3, busy[3] = 0, and the stall drops.
- Full queue (MC_DEPTH = 2): issue rd 4 then rd 6; a third mc_issue_d -> stall while mc_count = 2. After mc_done, mc_rd = 4 (in-order), mc_count = 1, and the stall releases.
- Priority and wrap: pcsrc_e = 1 coincident with a load-use hazard -> flush_d = flush_e = 1, stall_f = 0. Then 5 issue/complete pairs -> head/tail wrap, mc_rd order correct, mc_err = 0.
- Errors and reset: mc_done with mc_count = 0 -> mc_err = 1, sticky. Drop rst low mid-flight with mc_count = 1 -> busy, mc_count and mc_err all cleared immediately, without a clock edge.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard unit for the 5-stage core. It handles operand forwarding, load-use
//   stalls and branch flushes. It also keeps a register scoreboard and an
//   in-order completion queue, so a variable-latency multi-cycle unit
//   (mul/div) can run alongside the pipe.
//
// Ports
//   clk, rst                   clock; asynchronous active-low reset
//   rs1_d, rs2_d, rd_d         Decode source/destination indices
//   regwrite_d, mc_issue_d     Decode writes rd_d / is a multi-cycle op
//   rs1_e, rs2_e, rd_e         Execute indices
//   regwrite_e, resultsrc_e    Execute write enable / result source (01 = load)
//   mc_issue_e                 Execute op dispatched to the multi-cycle unit
//   pcsrc_e                    taken branch/jump in Execute
//   rd_m, regwrite_m           Memory-stage destination / write enable
//   rd_w, regwrite_w           Writeback-stage destination / write enable
//   mc_done                    multi-cycle unit retires its oldest op
//   forward_ae, forward_be     operand select: 00 regfile, 10 Memory, 01 Writeback
//   stall_f, stall_d           hold PC and IF/ID
//   flush_d, flush_e           clear IF/ID and ID/EX
//   mc_rd                      destination of the op completing now (queue head)
//   mc_count                   outstanding multi-cycle ops
//   busy                       per-register pending-write bits
//   mc_err                     sticky protocol-error flag
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int RW       = 5,
  parameter int MC_DEPTH = 2,
  parameter int CW       = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RW-1:0]   rs1_d,
  input  logic [RW-1:0]   rs2_d,
  input  logic [RW-1:0]   rd_d,
  input  logic            regwrite_d,
  input  logic            mc_issue_d,
  input  logic [RW-1:0]   rs1_e,
  input  logic [RW-1:0]   rs2_e,
  input  logic [RW-1:0]   rd_e,
  input  logic            regwrite_e,
  input  logic [1:0]      resultsrc_e,
  input  logic            mc_issue_e,
  input  logic            pcsrc_e,
  input  logic [RW-1:0]   rd_m,
  input  logic            regwrite_m,
  input  logic [RW-1:0]   rd_w,
  input  logic            regwrite_w,
  input  logic            mc_done,
  output logic [1:0]      forward_ae,
  output logic [1:0]      forward_be,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d,
  output logic            flush_e,
  output logic [RW-1:0]   mc_rd,
  output logic [CW-1:0]   mc_count,
  output logic [NREG-1:0] busy,
  output logic            mc_err
);

  localparam int PW   = (MC_DEPTH > 1) ? $clog2(MC_DEPTH) : 1;
  localparam int NIDX = 1 << RW;

  logic [NREG-1:0] busyReg, busyNext;
  logic [CW-1:0]   countReg, countNext;
  logic [PW-1:0]   headReg, tailReg;
  logic            errReg;
  logic [RW-1:0]   queueMem [MC_DEPTH];

  // Busy vector widened to the full index space, so any RW-bit index is in range.
  logic [NIDX-1:0] busyIdx;
  logic            queueEmpty, queueFull, pushOk, popOk, errEvent;
  logic            lwHaz, rawHaz, wawHaz, fullHaz, hz;

  function automatic logic [1:0] fwdSel(input logic [RW-1:0] rs,
                                        input logic wm, input logic [RW-1:0] rdm,
                                        input logic ww, input logic [RW-1:0] rdw);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (wm && rdm == rs)      sel = 2'b10;
      else if (ww && rdw == rs) sel = 2'b01;
    end
    return sel;
  endfunction

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(MC_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign forward_ae = fwdSel(rs1_e, regwrite_m, rd_m, regwrite_w, rd_w);
  assign forward_be = fwdSel(rs2_e, regwrite_m, rd_m, regwrite_w, rd_w);

  assign busyIdx    = NIDX'(busyReg);
  assign queueEmpty = (countReg == '0);
  assign queueFull  = (countReg == CW'(MC_DEPTH));
  assign popOk      = mc_done && !queueEmpty;
  // A full queue still accepts a push when the head retires in the same cycle.
  assign pushOk     = mc_issue_e && (!queueFull || mc_done);
  assign errEvent   = (mc_issue_e && queueFull && !mc_done) || (mc_done && queueEmpty);
  assign mc_rd      = queueEmpty ? '0 : queueMem[headReg];

  // Hazard detection
  assign lwHaz  = (resultsrc_e == 2'b01) && (rd_e != '0) &&
                  ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign rawHaz = ((rs1_d != '0) && busyIdx[rs1_d]) ||
                  ((rs2_d != '0) && busyIdx[rs2_d]) ||
                  (mc_issue_e && regwrite_e && (rd_e != '0) &&
                   ((rd_e == rs1_d) || (rd_e == rs2_d)));
  assign wawHaz = regwrite_d && (rd_d != '0) &&
                  (busyIdx[rd_d] || (mc_issue_e && (rd_e == rd_d)));
  // Ignores mc_done on purpose: keeps the check off the completion timing path.
  assign fullHaz = mc_issue_d &&
                   (({1'b0, countReg} + (CW+1)'(mc_issue_e)) >= (CW+1)'(MC_DEPTH));
  assign hz = lwHaz | rawHaz | wawHaz | fullHaz;

  // A redirect squashes the stalled Decode instruction, so it overrides the stall.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (pcsrc_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      stall_f = hz;
      stall_d = hz;
      flush_e = hz;
    end
  end

  always_comb begin
    countNext = countReg;
    case ({pushOk, popOk})
      2'b10:   countNext = countReg + 1'b1;
      2'b01:   countNext = countReg - 1'b1;
      default: countNext = countReg;
    endcase
  end

  // Scoreboard bits: clear on retire, set on issue. Set wins on a collision.
  // x0 is never tracked.
  assign busyNext[0] = 1'b0;
  for (genvar gi = 1; gi < NREG; gi++) begin : gBusy
    assign busyNext[gi] = (pushOk && regwrite_e && (rd_e == RW'(gi))) ||
                          (busyReg[gi] && !(popOk && (mc_rd == RW'(gi))));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busyReg  <= '0;
      countReg <= '0;
      headReg  <= '0;
      tailReg  <= '0;
      errReg   <= 1'b0;
    end else begin
      busyReg  <= busyNext;
      countReg <= countNext;
      if (pushOk) tailReg <= nextPtr(tailReg);
      if (popOk)  headReg <= nextPtr(headReg);
      if (errEvent) errReg <= 1'b1;
    end
  end

  // Queue storage needs no reset: mc_rd is gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (pushOk) queueMem[tailReg] <= rd_e;
  end

  assign mc_count = countReg;
  assign busy     = busyReg;
  assign mc_err   = errReg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic        regwrite_d, mc_issue_d, regwrite_e, mc_issue_e, pcsrc_e;
  logic        regwrite_m, regwrite_w, mc_done;
  logic [1:0]  resultsrc_e;
  logic [1:0]  forward_ae, forward_be;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [4:0]  mc_rd;
  logic [1:0]  mc_count;
  logic [31:0] busy;
  logic        mc_err;

  int vectors = 0;
  int miscompares = 0;

  hazard_scoreboard #(.NREG(32), .RW(5), .MC_DEPTH(2), .CW(2)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .mc_issue_d(mc_issue_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .regwrite_e(regwrite_e), .resultsrc_e(resultsrc_e),
    .mc_issue_e(mc_issue_e), .pcsrc_e(pcsrc_e),
    .rd_m(rd_m), .regwrite_m(regwrite_m),
    .rd_w(rd_w), .regwrite_w(regwrite_w),
    .mc_done(mc_done),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e),
    .mc_rd(mc_rd), .mc_count(mc_count), .busy(busy), .mc_err(mc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("vector %0d %s: observed %0h expected %0h", vectors, tag, obs, exp);
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rd_d = 0; regwrite_d = 0; mc_issue_d = 0;
    rs1_e = 0; rs2_e = 0; rd_e = 0; regwrite_e = 0; resultsrc_e = 2'b00;
    mc_issue_e = 0; pcsrc_e = 0; rd_m = 0; regwrite_m = 0;
    rd_w = 0; regwrite_w = 0; mc_done = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    mc_issue_e = 1; regwrite_e = 1; rd_e = rd;
  endtask

  task automatic noIssue();
    mc_issue_e = 0; regwrite_e = 0; rd_e = 0;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    repeat (2) tick();
    chk("reset_busy", busy, 0);
    chk("reset_count", mc_count, 0);
    chk("reset_err", mc_err, 0);
    rst = 1'b1;
    #1;
    chk("idle_stall", stall_f, 0);

    // Forwarding
    regwrite_m = 1; rd_m = 5; regwrite_w = 1; rd_w = 5; rs1_e = 5; rs2_e = 0;
    #1;
    chk("fwd_a_mem", forward_ae, 2'b10);
    chk("fwd_b_x0", forward_be, 2'b00);
    regwrite_m = 0; rs2_e = 5;
    #1;
    chk("fwd_a_wb", forward_ae, 2'b01);
    chk("fwd_b_wb", forward_be, 2'b01);
    rd_w = 6;
    #1;
    chk("fwd_a_none", forward_ae, 2'b00);
    idle();

    // Load-use
    resultsrc_e = 2'b01; rd_e = 7; rs2_d = 7;
    #1;
    chk("lw_stall_f", stall_f, 1);
    chk("lw_stall_d", stall_d, 1);
    chk("lw_flush_e", flush_e, 1);
    chk("lw_flush_d", flush_d, 0);
    pcsrc_e = 1;
    #1;
    chk("redir_flush_d", flush_d, 1);
    chk("redir_flush_e", flush_e, 1);
    chk("redir_stall_f", stall_f, 0);
    chk("redir_stall_d", stall_d, 0);
    pcsrc_e = 0; rd_e = 0;
    #1;
    chk("lw_x0_nostall", stall_f, 0);
    idle();
    tick();

    // Scoreboard RAW on rd 3
    issue(3); rs1_d = 3;
    #1;
    chk("raw_issue_stall", stall_f, 1);
    tick();
    noIssue();
    #1;
    chk("sb_busy3", busy, 32'h8);
    chk("sb_count1", mc_count, 1);
    chk("sb_stall", stall_d, 1);
    chk("sb_flush_e", flush_e, 1);
    tick();
    chk("sb_stall_hold", stall_f, 1);
    mc_done = 1;
    #1;
    chk("sb_mc_rd3", mc_rd, 3);
    tick();
    mc_done = 0;
    #1;
    chk("sb_busy_clr", busy, 0);
    chk("sb_count0", mc_count, 0);
    chk("sb_stall_drop", stall_f, 0);
    rs1_d = 0;

    // Full queue
    issue(4); tick();
    issue(6); tick();
    noIssue();
    regwrite_d = 1; rd_d = 6;
    #1;
    chk("waw_stall", stall_f, 1);
    regwrite_d = 0; rd_d = 0; mc_issue_d = 1;
    #1;
    chk("full_count2", mc_count, 2);
    chk("full_busy", busy, 32'h50);
    chk("full_stall", stall_d, 1);
    mc_done = 1;
    #1;
    chk("full_mc_rd4", mc_rd, 4);
    chk("full_ignores_done", stall_f, 1);
    tick();
    mc_done = 0;
    #1;
    chk("full_count1", mc_count, 1);
    chk("full_busy6", busy, 32'h40);
    chk("full_release", stall_f, 0);
    mc_issue_d = 0; mc_done = 1;
    #1;
    chk("full_mc_rd6", mc_rd, 6);
    tick();
    mc_done = 0;
    #1;
    chk("full_count0", mc_count, 0);

    // Wrap: five issue/complete pairs
    for (int k = 0; k < 5; k++) begin
      issue(5'(8 + k)); tick();
      noIssue(); mc_done = 1;
      #1;
      chk($sformatf("wrap_mc_rd_%0d", k), mc_rd, 8 + k);
      tick();
      mc_done = 0;
    end
    #1;
    chk("wrap_count0", mc_count, 0);
    chk("wrap_busy0", busy, 0);
    chk("wrap_err0", mc_err, 0);

    // Simultaneous push/pop at full
    issue(20); tick();
    issue(21); tick();
    issue(22); mc_done = 1;
    #1;
    chk("pp_mc_rd20", mc_rd, 20);
    tick();
    noIssue(); mc_done = 0;
    #1;
    chk("pp_count2", mc_count, 2);
    chk("pp_busy", busy, 32'h0060_0000);
    mc_done = 1;
    #1;
    chk("pp_mc_rd21", mc_rd, 21);
    tick();
    chk("pp_mc_rd22", mc_rd, 22);
    tick();
    mc_done = 0;
    #1;
    chk("pp_count0", mc_count, 0);
    chk("pp_err0", mc_err, 0);

    // Same register set and cleared in one cycle: set wins
    issue(9); tick();
    mc_done = 1; tick();
    noIssue(); mc_done = 0;
    #1;
    chk("setwin_busy9", busy, 32'h200);
    chk("setwin_count1", mc_count, 1);
    mc_done = 1;
    #1;
    chk("setwin_mc_rd9", mc_rd, 9);
    tick();
    mc_done = 0;
    #1;
    chk("setwin_busy0", busy, 0);

    // Underflow error
    mc_done = 1;
    #1;
    chk("uf_mc_rd0", mc_rd, 0);
    tick();
    mc_done = 0;
    #1;
    chk("uf_err", mc_err, 1);
    chk("uf_count0", mc_count, 0);
    tick();
    chk("uf_err_sticky", mc_err, 1);

    // Asynchronous reset mid-flight
    issue(12); tick();
    noIssue();
    #1;
    chk("mid_count1", mc_count, 1);
    chk("mid_busy12", busy, 32'h1000);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_count", mc_count, 0);
    chk("arst_err", mc_err, 0);
    #1;
    rst = 1'b1;
    tick();

    // Overflow: third push dropped
    issue(1); tick();
    issue(2); tick();
    issue(3); tick();
    noIssue();
    #1;
    chk("of_count2", mc_count, 2);
    chk("of_err", mc_err, 1);
    mc_done = 1;
    #1;
    chk("of_mc_rd1", mc_rd, 1);
    tick();
    chk("of_mc_rd2", mc_rd, 2);
    tick();
    mc_done = 0;
    #1;
    chk("of_count0", mc_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
